// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer and its
// Montgomery multiplier: default widths and the controller state encoding.
package mod_exp_ctrl_pkg;

   localparam int unsigned DEF_BITS     = 8;
   localparam int unsigned DEF_LOG_BITS = 3;

   typedef enum logic [2:0] {
      StIdle,
      StToMont,
      StInitAcc,
      StSqr,
      StMul,
      StFromMont,
      StDone
   } state_t;

   typedef enum logic [1:0] {
      MmIdle,
      MmIter,
      MmFinal
   } mm_phase_t;

endpackage

// File: rtl/mont_mult_seq.sv
// Radix-2 sequential Montgomery multiplier: result = a*b*2^-BITS mod m.
// Operands load on start; done and result appear BITS+2 cycles later.
module mont_mult_seq
   import mod_exp_ctrl_pkg::*;
#(
   parameter int unsigned BITS     = DEF_BITS,
   parameter int unsigned LOG_BITS = DEF_LOG_BITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [BITS-1:0] m,
   output logic [BITS-1:0] result,
   output logic            done
);

   mm_phase_t         phase_q, phase_d;
   logic [BITS-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
   logic [BITS+1:0]   t_q, t_d;
   logic [LOG_BITS:0] cnt_q, cnt_d;
   logic [BITS-1:0]   result_q, result_d;
   logic              done_q, done_d;

   // Partial sum stays below 4m, so two guard bits are enough.
   logic [BITS+1:0] sum_ab, sum_m, m_ext;

   always_comb begin
      m_ext  = {2'b00, m_q};
      sum_ab = t_q + (a_q[0] ? {2'b00, b_q} : '0);
      sum_m  = sum_ab[0] ? (sum_ab + m_ext) : sum_ab;
   end

   always_comb begin
      phase_d  = phase_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      t_d      = t_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      unique case (phase_q)
         MmIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               m_d     = m;
               t_d     = '0;
               cnt_d   = '0;
               phase_d = MmIter;
            end
         end
         MmIter: begin
            t_d   = sum_m >> 1;
            a_d   = a_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == (LOG_BITS+1)'(BITS-1)) begin
               phase_d = MmFinal;
            end
         end
         MmFinal: begin
            result_d = (t_q >= m_ext) ? BITS'(t_q - m_ext) : BITS'(t_q);
            done_d   = 1'b1;
            phase_d  = MmIdle;
         end
         default: phase_d = MmIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= MmIdle;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         t_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         t_q      <= t_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing z = x^e mod m
// through one shared sequential Montgomery multiplier.
module mod_exp_ctrl
   import mod_exp_ctrl_pkg::*;
#(
   parameter int unsigned BITS     = DEF_BITS,
   parameter int unsigned LOG_BITS = DEF_LOG_BITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [BITS-1:0] x,
   input  logic [BITS-1:0] e,
   input  logic [BITS-1:0] m,
   input  logic [BITS-1:0] r2,
   output logic [BITS-1:0] z,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [BITS-1:0]     x_q, x_d, e_q, e_d, m_q, m_d, r2_q, r2_d;
   logic [BITS-1:0]     xm_q, xm_d, acc_q, acc_d, z_q, z_d;
   logic [LOG_BITS-1:0] idx_q, idx_d;
   logic                err_q, err_d;
   logic                mm_start_q, mm_start_d;

   logic [BITS-1:0] mm_a, mm_b, mm_res;
   logic            mm_done;

   always_comb begin
      mm_a = acc_q;
      mm_b = acc_q;
      unique case (state_q)
         StToMont:   begin mm_a = x_q;   mm_b = r2_q; end
         StInitAcc:  begin mm_a = r2_q;  mm_b = ONE;  end
         StSqr:      begin mm_a = acc_q; mm_b = acc_q; end
         StMul:      begin mm_a = acc_q; mm_b = xm_q; end
         StFromMont: begin mm_a = acc_q; mm_b = ONE;  end
         default:    begin mm_a = acc_q; mm_b = acc_q; end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      e_d        = e_q;
      m_d        = m_q;
      r2_d       = r2_q;
      xm_d       = xm_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      z_d        = z_q;
      err_d      = err_q;
      mm_start_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               x_d   = x;
               e_d   = e;
               m_d   = m;
               r2_d  = r2;
               idx_d = LOG_BITS'(BITS-1);
               if (!m[0] || (x >= m)) begin
                  z_d     = '0;
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d    = StToMont;
                  mm_start_d = 1'b1;
               end
            end
         end
         StToMont: begin
            if (mm_done) begin
               xm_d       = mm_res;
               state_d    = StInitAcc;
               mm_start_d = 1'b1;
            end
         end
         StInitAcc: begin
            if (mm_done) begin
               acc_d      = mm_res;
               state_d    = StSqr;
               mm_start_d = 1'b1;
            end
         end
         StSqr: begin
            if (mm_done) begin
               acc_d      = mm_res;
               mm_start_d = 1'b1;
               if (e_q[idx_q]) begin
                  state_d = StMul;
               end else if (idx_q == '0) begin
                  state_d = StFromMont;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
         StMul: begin
            if (mm_done) begin
               acc_d      = mm_res;
               mm_start_d = 1'b1;
               if (idx_q == '0) begin
                  state_d = StFromMont;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = StSqr;
               end
            end
         end
         StFromMont: begin
            if (mm_done) begin
               z_d     = mm_res;
               err_d   = 1'b0;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         x_q        <= '0;
         e_q        <= '0;
         m_q        <= '0;
         r2_q       <= '0;
         xm_q       <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         z_q        <= '0;
         err_q      <= 1'b0;
         mm_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         e_q        <= e_d;
         m_q        <= m_d;
         r2_q       <= r2_d;
         xm_q       <= xm_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         z_q        <= z_d;
         err_q      <= err_d;
         mm_start_q <= mm_start_d;
      end
   end

   mont_mult_seq #(
      .BITS     (BITS),
      .LOG_BITS (LOG_BITS)
   ) u_mm (
      .clk    (clk),
      .rst    (rst),
      .start  (mm_start_q),
      .a      (mm_a),
      .b      (mm_b),
      .m      (m_q),
      .result (mm_res),
      .done   (mm_done)
   );

   assign z    = z_q;
   assign err  = err_q;
   assign done = (state_q == StDone);
   assign busy = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl at BITS=8: stimulus pushes expected
// results, a negedge monitor checks z/err/done timing and busy every cycle.
module tb_mod_exp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] x, e, m, r2;
   logic [7:0] z;
   logic       busy, done, err;

   typedef struct {
      logic [7:0] z;
      logic       err;
      int         start_cyc;
      int         done_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   mm_cnt = 0;

   mod_exp_ctrl #(
      .BITS     (8),
      .LOG_BITS (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .e     (e),
      .m     (m),
      .r2    (r2),
      .z     (z),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
      end
   endtask

   function automatic int pow_mod(input int b, input int ex, input int md);
      int r = 1 % md;
      for (int i = 7; i >= 0; i--) begin
         r = (r * r) % md;
         if (ex[i]) r = (r * b) % md;
      end
      return r;
   endfunction

   function automatic int n_ops(input int ex);
      int n = 3 + 8;
      for (int i = 0; i < 8; i++) n += ex[i];
      return n;
   endfunction

   // Monitor: every cycle checks busy against the head entry, pops on done.
   always @(negedge clk) begin
      exp_t ent;
      logic eb;
      if (!rst) begin
         eb = (sb.size() > 0) && !sb[0].err && (cyc > sb[0].start_cyc) &&
              (cyc < sb[0].done_cyc);
         check("busy", int'(busy), int'(eb));
         if (dut.mm_start_q) mm_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               ent = sb.pop_front();
               check("z", int'(z), int'(ent.z));
               check("err", int'(err), int'(ent.err));
               check("done_cycle", cyc, ent.done_cyc);
            end
         end
      end
   end

   task automatic issue(input int xv, input int ev, input int mv, input int exp_z);
      exp_t ent;
      @(posedge clk);
      #1;
      x     = 8'(xv);
      e     = 8'(ev);
      m     = 8'(mv);
      r2    = 8'((1 << 16) % mv);
      start = 1'b1;
      ent.err       = (mv % 2 == 0) || (xv >= mv);
      ent.z         = ent.err ? 8'd0 : 8'(exp_z);
      ent.start_cyc = cyc;
      ent.done_cyc  = ent.err ? cyc + 1 : cyc + n_ops(ev) * 11 + 1;
      sb.push_back(ent);
      @(posedge clk);
      #1;
      start = 1'b0;
      // Operands are registered on accept; scramble them afterwards.
      x  = 8'($urandom);
      e  = 8'($urandom);
      m  = 8'($urandom);
      r2 = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic pulse_at(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
      x     = 8'd1;
      e     = 8'd1;
      m     = 8'd13;
      r2    = 8'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      int c0, snap, mv, xv, ev;
      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      e     = '0;
      m     = '0;
      r2    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_z", int'(z), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      rst = 1'b0;

      issue(4, 13, 13, 4);
      wait_idle();
      issue(2, 10, 13, 10);
      wait_idle();
      issue(5, 0, 13, 1);
      wait_idle();

      // Restarts during a run must be ignored.
      issue(4, 13, 13, 4);
      c0 = sb[0].start_cyc;
      pulse_at(c0 + 5);
      pulse_at(c0 + 60);
      wait_idle();

      snap = mm_cnt;
      issue(4, 5, 12, 0);
      wait_idle();
      check("no_mm_start_even_m", mm_cnt - snap, 0);
      snap = mm_cnt;
      issue(13, 5, 13, 0);
      wait_idle();
      check("no_mm_start_x_ge_m", mm_cnt - snap, 0);

      // Asynchronous abort mid-run, err still held high from the last case.
      issue(2, 10, 13, 10);
      c0 = sb[0].start_cyc;
      while (cyc < c0 + 40) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      check("abort_z", int'(z), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_err", int'(err), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      issue(2, 10, 13, 10);
      wait_idle();

      for (int i = 0; i < 200; i++) begin
         mv = 2 * int'($urandom_range(1, 127)) + 1;
         xv = int'($urandom_range(0, mv - 1));
         ev = int'($urandom_range(0, 255));
         issue(xv, ev, mv, pow_mod(xv, ev, mv));
         wait_idle();
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
